// File: rtl/toggle_pulse_debouncer.sv
// Pushbutton conditioner: 2-flop synchroniser, press/release qualification FSM,
// one-cycle toggle pulse per press. Define TPD_AUTOREPEAT_EN to add auto-repeat while held.
module toggle_pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_in,
  output logic       t_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PC_W  = 8;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65536) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..65536");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65536) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be in 2..65536");
  end

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_btn_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_t_pulse;
  logic             w_t_pulse_nxt;
  logic             r_btn_level;
  logic             w_btn_level_nxt;
  logic [PC_W-1:0]  r_press_count;
  logic [PC_W-1:0]  w_press_count_nxt;
  logic             w_cnt_done;
  logic             w_rep_hit;

  // Synchroniser runs independently of ena so the FSM never sees a stale level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_sync = r_sync2;
  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_t_pulse     <= 1'b0;
      r_btn_level   <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_t_pulse     <= w_t_pulse_nxt;
      r_btn_level   <= w_btn_level_nxt;
      r_press_count <= w_press_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_t_pulse_nxt     = 1'b0;
    w_btn_level_nxt   = r_btn_level;
    w_press_count_nxt = r_press_count;
    if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_btn_sync) begin
            w_state_nxt = S_PRESS_CHK;
            w_cnt_nxt   = '0;
          end
        end
        S_PRESS_CHK: begin
          if (!w_btn_sync) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_cnt_done) begin
            w_state_nxt       = S_PRESSED;
            w_cnt_nxt         = '0;
            w_t_pulse_nxt     = 1'b1;
            w_btn_level_nxt   = 1'b1;
            w_press_count_nxt = PC_W'(r_press_count + 1'b1);
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
        S_PRESSED: begin
          if (!w_btn_sync) begin
            w_state_nxt = S_RELEASE_CHK;
            w_cnt_nxt   = '0;
          end
          if (w_rep_hit) begin
            w_t_pulse_nxt     = 1'b1;
            w_press_count_nxt = PC_W'(r_press_count + 1'b1);
          end
        end
        S_RELEASE_CHK: begin
          if (w_btn_sync) begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_done) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = '0;
            w_btn_level_nxt = 1'b0;
          end else begin
            w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef TPD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  logic [REP_W-1:0] r_rep_cnt;

  assign w_rep_hit = (r_state == S_PRESSED) && (r_rep_cnt == REP_W'(REPEAT_CYCLES - 1));

  // Repeat timer restarts on each entry to PRESSED and holds through RELEASE_CHK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (ena) begin
      if (w_state_nxt == S_PRESSED && r_state != S_PRESSED) begin
        r_rep_cnt <= '0;
      end else if (r_state == S_PRESSED) begin
        r_rep_cnt <= w_rep_hit ? '0 : REP_W'(r_rep_cnt + 1'b1);
      end
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  assign t_pulse     = r_t_pulse;
  assign btn_level   = r_btn_level;
  assign press_count = r_press_count;

endmodule

// File: doc/toggle_pulse_debouncer.md
# toggle_pulse_debouncer

Conditions a raw, bouncing pushbutton into a clean single-cycle toggle pulse. Sits directly upstream of the design's T flip-flop stage: `t_pulse` drives that stage's T input, so each physical press toggles Q exactly once. It synchronises the asynchronous button, rejects bounce with a press/release qualification FSM, and exposes the debounced level and a wrapping press counter for observation.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to accept a press or a release; legal range 2..65536.
- `REPEAT_CYCLES`, default 1024: auto-repeat period in cycles; used only when `TPD_AUTOREPEAT_EN` is defined; legal range 2..65536.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: stage enable; low freezes FSM and counters.
- `btn_in` input 1: raw asynchronous button, active-high.
- `t_pulse` output 1: registered one-cycle pulse per accepted press (and per repeat when enabled).
- `btn_level` output 1: registered debounced button level.
- `press_count` output 8: count of `t_pulse` assertions, wraps 255->0.

## Operation
- Synchroniser: two flops, reset 0; `btn_sync` = second flop. Runs regardless of `ena`.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES)`, cleared on every state change.
- FSM states (reset to IDLE):
  - IDLE: `btn_sync`=1 -> PRESS_CHK, counter cleared.
  - PRESS_CHK: `btn_sync`=0 -> IDLE (bounce rejected, no pulse). `btn_sync`=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED; `t_pulse`<=1 and `btn_level`<=1 on the same edge. Otherwise counter++.
  - PRESSED: `btn_sync`=0 -> RELEASE_CHK, counter cleared.
  - RELEASE_CHK: `btn_sync`=1 -> PRESSED with no new pulse. `btn_sync`=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; `btn_level`<=0. Otherwise counter++.
- `t_pulse` is high for exactly one cycle per qualifying event, then returns to 0.
- `press_count` increments on every edge that sets `t_pulse`; 255 wraps to 0 silently.
- `ena`=0: state, counters, `btn_level` and `press_count` hold; `t_pulse` is driven 0. A pulse due on an edge where `ena`=0 is not emitted and is not deferred.

## Timing
- Reset values: `t_pulse`=0, `btn_level`=0, `press_count`=0, both synchroniser flops 0, FSM in IDLE, all counters 0.
- Reset is asynchronous: asserting `rst_n` mid-qualification or while PRESSED aborts immediately; no pulse is emitted on release of reset.
- Press latency: if `btn_in` is first sampled high at edge n and stays high, `t_pulse` rises at edge n+DEBOUNCE_CYCLES+2 and falls one edge later.
- Release latency: `btn_level` falls at edge m+DEBOUNCE_CYCLES+2, where m is the first edge sampling `btn_in` low.
- A high glitch shorter than DEBOUNCE_CYCLES+1 synchronised samples produces no pulse and no `btn_level` change.
- A low glitch while pressed, shorter than DEBOUNCE_CYCLES+1 samples, produces no second pulse.
- Minimum press-to-press period: 2*(DEBOUNCE_CYCLES+1) cycles.

## Configuration
- `TPD_AUTOREPEAT_EN` defined: adds a repeat counter of width `$clog2(REPEAT_CYCLES)`.
  - The counter is cleared on every entry to PRESSED and increments each cycle in PRESSED while `ena`=1.
  - At REPEAT_CYCLES-1 it asserts `t_pulse` for one cycle, increments `press_count` and clears.
  - The first repeat occurs REPEAT_CYCLES cycles after the initial pulse.
  - The counter holds in RELEASE_CHK; it is cleared on the return to PRESSED.
- `TPD_AUTOREPEAT_EN` undefined: repeat logic is absent; exactly one pulse per accepted press, however long the button is held.

## Test plan
- Reset, then `btn_in`=1 held 40 cycles with DEBOUNCE_CYCLES=4 -> single `t_pulse` at edge n+6, `btn_level`=1, `press_count`=1.
- Bounce train 1,0,1,0 with 2-cycle phases, then stable 0 (DEBOUNCE_CYCLES=4) -> no `t_pulse`, `btn_level` stays 0.
- Press, then a 2-cycle low glitch, then held high -> exactly one pulse, `btn_level` stays 1, `press_count`=1.
- 256 clean press/release cycles -> `press_count` returns to 0; 257th press -> 1.
- `rst_n` asserted at PRESS_CHK counter=2 -> all outputs 0 immediately; no pulse after deassertion until a fresh full qualification completes.
- With `TPD_AUTOREPEAT_EN`, REPEAT_CYCLES=8, button held 30 cycles after the initial pulse -> repeat pulses at +8, +16 and +24 cycles, `press_count`=4; with `ena`=0 during hold -> no pulses and counters frozen.
